// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose:
//   Decodes an RV32 instruction word plus the 2-bit ALUop from the main
//   decoder into the 4-bit ALU control code and executes the operation.
//   Base operations take one cycle. Iterative multiply/divide/remainder take
//   XLEN+1 cycles from accept to out_valid. A valid/ready handshake on both
//   sides lets the core stall on long operations.
//
// Configuration macro:
//   ALU_MDU_EN  defined   : mul/div/rem are executed (ITER state present).
//               undefined : every R-type with instruction[25] = 1 decodes to
//                           the illegal code; ITER is unreachable, busy = 0.
//
// Parameters:
//   XLEN     operand/result width (power of two, 8 or more).
//   SHAMT_W  shift-amount width, $clog2(XLEN) (local, not overridable).
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   in_valid        in   instruction/operands presented
//   in_ready        out  unit can accept (IDLE only)
//   instruction     in   RV32 instruction word (32 bits)
//   ALUop           in   00 LUI/JAL, 01 branch, 10 I-type, 11 R-type
//   op_a            in   source A (XLEN)
//   op_b            in   source B or immediate (XLEN)
//   control_signal  out  decoded control code, registered on accept
//   result          out  operation result (XLEN)
//   out_valid       out  result valid, held until out_ready
//   out_ready       in   consumer takes the result
//   illegal         out  unsupported encoding, qualified by out_valid
//   busy            out  high while iterating
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [1:0]      ALUop,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      control_signal,
    output logic [XLEN-1:0] result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            illegal,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] C_ADD   = 4'b0000;
    localparam logic [3:0] C_SUB   = 4'b0001;
    localparam logic [3:0] C_AND   = 4'b0010;
    localparam logic [3:0] C_OR    = 4'b0011;
    localparam logic [3:0] C_XOR   = 4'b0100;
    localparam logic [3:0] C_SLT   = 4'b0101;
    localparam logic [3:0] C_SLTU  = 4'b0110;
    localparam logic [3:0] C_PASSB = 4'b0111;
    localparam logic [3:0] C_SLL   = 4'b1000;
    localparam logic [3:0] C_PASSA = 4'b1001;
    localparam logic [3:0] C_SRL   = 4'b1010;
    localparam logic [3:0] C_SRA   = 4'b1011;
    localparam logic [3:0] C_MUL   = 4'b1100;
    localparam logic [3:0] C_DIV   = 4'b1101;
    localparam logic [3:0] C_REM   = 4'b1110;
    localparam logic [3:0] C_ILL   = 4'b1111;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    // I-type style decode of funct3, shared by the R-type base ops.
    function automatic logic [3:0] decode_itype(input logic [2:0] f3, input logic b30);
        logic [3:0] code;
        case (f3)
            3'b000:  code = C_ADD;
            3'b001:  code = C_SLL;
            3'b010:  code = C_SLT;
            3'b011:  code = C_SLTU;
            3'b100:  code = C_XOR;
            3'b101:  code = b30 ? C_SRA : C_SRL;
            3'b110:  code = C_OR;
            3'b111:  code = C_AND;
            default: code = C_ILL;
        endcase
        return code;
    endfunction

    // Full decode of instruction + ALUop into the control code.
    function automatic logic [3:0] decode_ctrl(input logic [31:0] insn, input logic [1:0] aluop);
        logic [3:0] code;
        logic [2:0] f3;
        f3 = insn[14:12];
        case (aluop)
            2'b00:   code = (insn[6:0] == OPC_LUI) ? C_PASSB : C_PASSA;
            2'b01:   code = C_SUB;
            2'b10:   code = decode_itype(f3, insn[30]);
            2'b11: begin
                if (insn[25]) begin
`ifdef ALU_MDU_EN
                    case (f3)
                        3'b000:         code = C_MUL;
                        3'b100, 3'b101: code = C_DIV;
                        3'b110, 3'b111: code = C_REM;
                        default:        code = C_ILL;   // mulh family
                    endcase
`else
                    code = C_ILL;
`endif
                end else if ((f3 == 3'b000) && insn[30]) begin
                    code = C_SUB;
                end else begin
                    code = decode_itype(f3, insn[30]);
                end
            end
            default: code = C_ILL;
        endcase
        return code;
    endfunction

    // Single-cycle datapath; mul/div/rem and illegal codes yield zero here.
    function automatic logic [XLEN-1:0] base_op(input logic [3:0] code,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0]    r;
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (code)
            C_ADD:   r = a + b;
            C_SUB:   r = a - b;
            C_AND:   r = a & b;
            C_OR:    r = a | b;
            C_XOR:   r = a ^ b;
            C_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            C_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
            C_PASSB: r = b;
            C_SLL:   r = a << sh;
            C_PASSA: r = a;
            C_SRL:   r = a >> sh;
            C_SRA:   r = $unsigned($signed(a) >>> sh);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_ctrl;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    logic [3:0]      w_dec;
    logic            w_accept;
    logic [XLEN-1:0] w_acc_result;
    logic            w_goes_iter;
    logic            w_iter_last;
    logic            w_unused;

    assign w_dec    = decode_ctrl(instruction, ALUop);
    assign w_accept = in_valid & in_ready;
    // Instruction fields the decoder never looks at.
    assign w_unused = ^{instruction[31], instruction[29:26], instruction[24:15], instruction[11:7]};

`ifdef ALU_MDU_EN
    localparam logic [XLEN-1:0]    MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN-1);

    // Multiply: r_a multiplicand (shifts left), r_b multiplier (shifts right),
    // r_acc partial product. Divide: r_quo dividend shifting into quotient,
    // r_b divisor magnitude, r_acc partial remainder.
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_quo;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic [XLEN-1:0]    w_mul_nxt;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_diff;
    logic               w_fits;
    logic [XLEN-1:0]    w_rem_nxt;
    logic [XLEN-1:0]    w_quo_nxt;
    logic [XLEN-1:0]    w_iter_result;

    // funct3[0] = 0 selects signed div/rem.
    assign w_signed_op = ~instruction[12];
    assign w_a_neg     = w_signed_op & op_a[XLEN-1];
    assign w_b_neg     = w_signed_op & op_b[XLEN-1];
    // Negating the most-negative value gives 2^(XLEN-1), its correct magnitude.
    assign w_a_mag     = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag     = w_b_neg ? (~op_b + 1'b1) : op_b;

    assign w_mul_nxt   = r_b[0] ? (r_acc + r_a) : r_acc;
    // Restoring step: shift in the next dividend bit, try subtracting divisor.
    assign w_rem_sh    = {r_acc, r_quo[XLEN-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_b};
    assign w_fits      = ~w_diff[XLEN];
    assign w_rem_nxt   = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt   = {r_quo[XLEN-2:0], w_fits};
    assign w_iter_last = (r_cnt == CNT_LAST);

    // Final-step result with the sign fix-up applied to magnitudes.
    always_comb begin
        w_iter_result = w_mul_nxt;
        case (r_ctrl)
            C_DIV:   w_iter_result = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
            C_REM:   w_iter_result = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
            default: w_iter_result = w_mul_nxt;
        endcase
    end

    // Accept-time result, including the divide special cases that skip ITER.
    always_comb begin
        w_acc_result = base_op(w_dec, op_a, op_b);
        w_goes_iter  = 1'b0;
        if ((w_dec == C_DIV) || (w_dec == C_REM)) begin
            if (op_b == '0) begin
                w_acc_result = (w_dec == C_DIV) ? '1 : op_a;
            end else if (w_signed_op && (op_a == MOST_NEG) && (op_b == '1)) begin
                w_acc_result = (w_dec == C_DIV) ? op_a : '0;
            end else begin
                w_goes_iter = 1'b1;
            end
        end else if (w_dec == C_MUL) begin
            w_goes_iter = 1'b1;
        end else begin
            w_goes_iter = 1'b0;
        end
    end

    // Iterative multiply/divide operand and step-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= (w_dec == C_MUL) ? op_b : w_b_mag;
            r_acc   <= '0;
            r_quo   <= w_a_mag;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_state == ST_ITER) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_ctrl == C_MUL) begin
                r_acc <= w_mul_nxt;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end else begin
                r_acc <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end
`else
    assign w_acc_result = base_op(w_dec, op_a, op_b);
    assign w_goes_iter  = 1'b0;
    assign w_iter_last  = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_goes_iter ? ST_ITER : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (w_iter_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
`ifdef ALU_MDU_EN
        busy      = (r_state == ST_ITER);
`else
        busy      = 1'b0;
`endif
    end

    // Result, control code and illegal flag; captured on accept or final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= 4'b0000;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= w_dec;
            r_result  <= w_acc_result;
            r_illegal <= (w_dec == C_ILL);
`ifdef ALU_MDU_EN
        end else if ((r_state == ST_ITER) && w_iter_last) begin
            r_result  <= w_iter_result;
`endif
        end else begin
            r_result  <= r_result;
        end
    end

    assign control_signal = r_ctrl;
    assign result         = r_result;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed self-checking bench for alu_exec_unit (XLEN = 32). Each vector
// carries a hand-computed result, control code, illegal flag, latency and
// busy-cycle count. mul/div/rem vectors are present when ALU_MDU_EN is set;
// otherwise the M-extension encodings are checked as illegal.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [1:0]  ALUop;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  control_signal;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        illegal;
    logic        busy;

    int total_cnt;
    int bad_cnt;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .ALUop          (ALUop),
        .op_a           (op_a),
        .op_b           (op_b),
        .control_signal (control_signal),
        .result         (result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .illegal        (illegal),
        .busy           (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single accepting edge.
    task automatic issue(input string tag, input logic [31:0] insn, input logic [1:0] aluop,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check_val({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        instruction = insn;
        ALUop       = aluop;
        op_a        = a;
        op_b        = b;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
    endtask

    // Wait for out_valid, check outputs, optionally stall, then retire.
    task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_code,
                             input logic exp_ill, input int exp_lat, input int exp_busy,
                             input int hold_cycles);
        int lat;
        int busy_seen;
        lat       = 1;
        busy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".busy_cycles"}, 64'(busy_seen), 64'(exp_busy));
        check_val({tag, ".result"}, {32'd0, result}, {32'd0, exp_res});
        check_val({tag, ".code"}, {60'd0, control_signal}, {60'd0, exp_code});
        check_val({tag, ".illegal"}, {63'd0, illegal}, {63'd0, exp_ill});
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            instruction = mk_insn(7'b0000000, 3'b100, OPC_R);
            ALUop       = 2'b11;
            op_a        = 32'h5555_5555;
            op_b        = 32'h0000_00FF;
            in_valid    = 1'b1;
            @(posedge clk);
            #1;
            check_val({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
            check_val({tag, ".hold_result"}, {32'd0, result}, {32'd0, exp_res});
            check_val({tag, ".hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, ".retire_valid"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, ".retire_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] insn, input logic [1:0] aluop,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_code, input logic exp_ill, input int exp_lat,
                          input int exp_busy);
        issue(tag, insn, aluop, a, b);
        finish_op(tag, exp_res, exp_code, exp_ill, exp_lat, exp_busy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".result"}, {32'd0, result}, 64'd0);
        check_val({tag, ".code"}, {60'd0, control_signal}, 64'd0);
        check_val({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, ".illegal"}, {63'd0, illegal}, 64'd0);
        check_val({tag, ".busy"}, {63'd0, busy}, 64'd0);
        check_val({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        total_cnt   = 0;
        bad_cnt     = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = 32'd0;
        ALUop       = 2'b00;
        op_a        = 32'd0;
        op_b        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        run_op("sub", mk_insn(7'b0100000, 3'b000, OPC_R), 2'b11, 32'd10, 32'd3,
               32'd7, 4'b0001, 1'b0, 1, 0);
        run_op("srai", mk_insn(7'b0100000, 3'b101, OPC_I), 2'b10, 32'h8000_0000, 32'd4,
               32'hF800_0000, 4'b1011, 1'b0, 1, 0);
        run_op("lui", mk_insn(7'b0000000, 3'b000, OPC_LUI), 2'b00, 32'h0, 32'h1234_5000,
               32'h1234_5000, 4'b0111, 1'b0, 1, 0);
        run_op("jal", mk_insn(7'b0000000, 3'b000, OPC_JAL), 2'b00, 32'h0000_0100, 32'h4,
               32'h0000_0100, 4'b1001, 1'b0, 1, 0);
        run_op("branch", mk_insn(7'b0000000, 3'b000, OPC_BR), 2'b01, 32'd5, 32'd5,
               32'd0, 4'b0001, 1'b0, 1, 0);
        run_op("add_wrap", mk_insn(7'b0000000, 3'b000, OPC_R), 2'b11, 32'hFFFF_FFFF, 32'd1,
               32'd0, 4'b0000, 1'b0, 1, 0);
        run_op("slt", mk_insn(7'b0000000, 3'b010, OPC_R), 2'b11, 32'hFFFF_FFFF, 32'd1,
               32'd1, 4'b0101, 1'b0, 1, 0);
        run_op("sltu", mk_insn(7'b0000000, 3'b011, OPC_R), 2'b11, 32'hFFFF_FFFF, 32'd1,
               32'd0, 4'b0110, 1'b0, 1, 0);
        run_op("slli", mk_insn(7'b0000000, 3'b001, OPC_I), 2'b10, 32'd1, 32'h0000_0025,
               32'h0000_0020, 4'b1000, 1'b0, 1, 0);
        run_op("srli", mk_insn(7'b0000000, 3'b101, OPC_I), 2'b10, 32'h8000_0000, 32'd4,
               32'h0800_0000, 4'b1010, 1'b0, 1, 0);
        run_op("or", mk_insn(7'b0000000, 3'b110, OPC_R), 2'b11, 32'h0000_F0F0, 32'h0000_0FF0,
               32'h0000_FFF0, 4'b0011, 1'b0, 1, 0);
        run_op("andi", mk_insn(7'b0000000, 3'b111, OPC_I), 2'b10, 32'h0000_F0F0, 32'h0000_0FF0,
               32'h0000_00F0, 4'b0010, 1'b0, 1, 0);

        // xor with a 5-cycle stall; stray in_valid must be ignored meanwhile.
        issue("xor_hold", mk_insn(7'b0000000, 3'b100, OPC_R), 2'b11, 32'h0000_F0F0, 32'h0000_0FF0);
        finish_op("xor_hold", 32'h0000_FF00, 4'b0100, 1'b0, 1, 0, 5);

        // mulh family is illegal in either build.
        run_op("mulh", mk_insn(7'b0000001, 3'b001, OPC_R), 2'b11, 32'd6, 32'd7,
               32'd0, 4'b1111, 1'b1, 1, 0);

`ifdef ALU_MDU_EN
        issue("mul_hold", mk_insn(7'b0000001, 3'b000, OPC_R), 2'b11, 32'hFFFF_FFFF, 32'd3);
        finish_op("mul_hold", 32'hFFFF_FFFD, 4'b1100, 1'b0, 33, 32, 5);
        run_op("div", mk_insn(7'b0000001, 3'b100, OPC_R), 2'b11, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFD, 4'b1101, 1'b0, 33, 32);
        run_op("rem", mk_insn(7'b0000001, 3'b110, OPC_R), 2'b11, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 4'b1110, 1'b0, 33, 32);
        run_op("divu", mk_insn(7'b0000001, 3'b101, OPC_R), 2'b11, 32'd100, 32'd7,
               32'd14, 4'b1101, 1'b0, 33, 32);
        run_op("remu", mk_insn(7'b0000001, 3'b111, OPC_R), 2'b11, 32'd100, 32'd7,
               32'd2, 4'b1110, 1'b0, 33, 32);
        run_op("divu_zero", mk_insn(7'b0000001, 3'b101, OPC_R), 2'b11, 32'h0000_1234, 32'd0,
               32'hFFFF_FFFF, 4'b1101, 1'b0, 1, 0);
        run_op("rem_zero", mk_insn(7'b0000001, 3'b110, OPC_R), 2'b11, 32'h0000_1234, 32'd0,
               32'h0000_1234, 4'b1110, 1'b0, 1, 0);
        run_op("div_ovf", mk_insn(7'b0000001, 3'b100, OPC_R), 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 4'b1101, 1'b0, 1, 0);
        run_op("rem_ovf", mk_insn(7'b0000001, 3'b110, OPC_R), 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 4'b1110, 1'b0, 1, 0);

        // Reset in the middle of an iterating divide.
        issue("div_abort", mk_insn(7'b0000001, 3'b100, OPC_R), 2'b11, 32'd1000, 32'd3);
        check_val("div_abort.busy", {63'd0, busy}, 64'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("div_abort_reset");
`else
        run_op("mul_nomdu", mk_insn(7'b0000001, 3'b000, OPC_R), 2'b11, 32'hFFFF_FFFF, 32'd3,
               32'd0, 4'b1111, 1'b1, 1, 0);
        run_op("div_nomdu", mk_insn(7'b0000001, 3'b100, OPC_R), 2'b11, 32'd9, 32'd2,
               32'd0, 4'b1111, 1'b1, 1, 0);

        // Reset while holding an illegal result in DONE.
        issue("ill_abort", mk_insn(7'b0000001, 3'b000, OPC_R), 2'b11, 32'd5, 32'd6);
        check_val("ill_abort.out_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("ill_abort_reset");
`endif

        run_op("add_after_reset", mk_insn(7'b0000000, 3'b000, OPC_R), 2'b11, 32'd1, 32'd1,
               32'd2, 4'b0000, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
